// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared definitions for the instruction-fetch slice: default widths, the
//   default reset PC and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int          DEF_PC_W     = 32;
  localparam int          DEF_INST_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  // IDLE: waiting for the skid buffer to drain before issuing a new read.
  // REQ : imem_req held high with a stable address until granted.
  // WAIT: one read outstanding, waiting for its rvalid.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// ---------------------------------------------------------------------------
// if_skid_buf
//   One-entry {inst, pc} holding buffer. It catches a fetch response that
//   arrives while the IF/ID register is stalled.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   push                load push_inst/push_pc into the entry
//   pop                 entry consumed by the IF/ID register
//   flush               discard the entry (redirect); wins over push/pop
//   push_inst, push_pc  incoming response
//   full                entry holds valid data
//   head_inst, head_pc  stored entry
// ---------------------------------------------------------------------------
module if_skid_buf
  import inst_fetch_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [INST_W-1:0] push_inst,
  input  logic [PC_W-1:0]   push_pc,
  output logic              full,
  output logic [INST_W-1:0] head_inst,
  output logic [PC_W-1:0]   head_pc
);

  // A push in the same cycle as a pop replaces the entry, so the buffer
  // stays full and order is kept (old entry leaves, new one arrives).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      head_inst <= '0;
      head_pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full      <= 1'b1;
      head_inst <= push_inst;
      head_pc   <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction-fetch stage. Owns the PC, issues one-outstanding word reads to
//   instruction memory and hands {inst, pc, pc+1} to decode through the IF/ID
//   register. Branch redirects replace the PC and flush wrong-path fetches.
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req, imem_addr           read request / word address (held until gnt)
//   imem_gnt                      request accepted this cycle
//   imem_rvalid, imem_rdata       read response, one per accepted request
//   br_taken, br_target           redirect pulse and its target address
//   id_stall                      decode cannot accept; IF/ID holds
//   if_valid, if_inst             IF/ID valid flag and instruction
//   if_pc, if_pc_next             address of if_inst and its +1 link value
// ---------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INST_W   = DEF_INST_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_pc_next
);

  fetch_state_e      state, state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   inflight_pc;
  logic              drop;

  logic              req_fire;
  logic              resp_seen;
  logic              resp_ok;
  logic              ifid_adv;
  logic              skid_push;
  logic              skid_pop;
  logic              skid_full;
  logic              skid_next_full;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_pc;

  // The address is the PC itself; a redirect while REQ is held simply moves
  // the PC, so the new address appears the following cycle.
  assign imem_addr = pc;

  assign req_fire  = (state == ST_REQ) && imem_gnt;
  assign resp_seen = (state == ST_WAIT) && imem_rvalid;
  // A response is useful only if it is not the stale one covered by drop and
  // does not collide with a redirect (which makes it wrong-path).
  assign resp_ok   = resp_seen && !drop && !br_taken;

  // IF/ID can take new data when it is empty or being consumed this cycle.
  assign ifid_adv  = !if_valid || !id_stall;
  assign skid_pop  = ifid_adv && skid_full && !br_taken;
  assign skid_push = resp_ok && (!ifid_adv || skid_full);
  assign skid_next_full = !br_taken && (skid_push || (skid_full && !skid_pop));

  if_skid_buf #(
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (skid_push),
    .pop       (skid_pop),
    .flush     (br_taken),
    .push_inst (imem_rdata),
    .push_pc   (inflight_pc),
    .full      (skid_full),
    .head_inst (skid_inst),
    .head_pc   (skid_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request output. imem_req depends only on the registered
  // state, so br_taken never reaches it combinationally.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!skid_full) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = skid_next_full ? ST_IDLE : ST_REQ;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // PC: a redirect wins over the post-grant increment so the first fetch
  // after a branch uses br_target exactly. The increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      if (br_taken) begin
        pc <= br_target;
      end else if (req_fire) begin
        pc <= pc + PC_W'(1);
      end
      if (req_fire) begin
        inflight_pc <= pc;
      end
    end
  end

  // drop marks that the single outstanding read belongs to the old path.
  // Whatever response arrives next consumes it, so repeated redirects while
  // it is set only move the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (resp_seen) begin
      drop <= 1'b0;
    end else if (br_taken && (req_fire || (state == ST_WAIT))) begin
      drop <= 1'b1;
    end
  end

  // IF/ID register: the skid entry is older than any new response, so it
  // refills first. A redirect empties IF/ID even under id_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_inst    <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
    end else if (br_taken) begin
      if_valid <= 1'b0;
    end else if (ifid_adv) begin
      if (skid_full) begin
        if_valid   <= 1'b1;
        if_inst    <= skid_inst;
        if_pc      <= skid_pc;
        if_pc_next <= skid_pc + PC_W'(1);
      end else if (resp_ok) begin
        if_valid   <= 1'b1;
        if_inst    <= imem_rdata;
        if_pc      <= inflight_pc;
        if_pc_next <= inflight_pc + PC_W'(1);
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. A behavioural memory answers requests with
//   a programmable grant enable and response latency; each task drives one
//   scenario and checks the outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt = 1'b0;
  logic              imem_rvalid = 1'b0;
  logic [INST_W-1:0] imem_rdata = '0;
  logic              br_taken = 1'b0;
  logic [PC_W-1:0]   br_target = '0;
  logic              id_stall = 1'b0;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic [PC_W-1:0]   if_pc_next;

  int total = 0;
  int bad   = 0;

  // memory model controls (written by tests, read by the responder only)
  int lat       = 1;
  bit gnt_en    = 1'b1;
  bit inject_rv = 1'b0;

  // responder private state
  bit          pend = 1'b0;
  int          cnt  = 0;
  logic [31:0] pend_addr = '0;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_pc_next  (if_pc_next)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory drives on the falling edge: gnt for a held request, rvalid `lat`
  // cycles after the handshake, or a stray rvalid when inject_rv is set.
  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end
    if (inject_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (rst_n) begin
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      if (imem_req && gnt_en && !pend) begin
        imem_gnt  = 1'b1;
        pend      = 1'b1;
        pend_addr = imem_addr;
        cnt       = lat;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int latency);
    rst_n     = 1'b0;
    br_taken  = 1'b0;
    br_target = '0;
    id_stall  = 1'b0;
    gnt_en    = 1'b1;
    inject_rv = 1'b0;
    lat       = latency;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Reset values, then exact first-fetch latency with k=1.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_req: req=%0b addr=%h want req=0 addr=0", imem_req, imem_addr);
    end
    total++;
    if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0 || if_pc_next !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_ifid: v=%0b inst=%h pc=%h pcn=%h want all 0",
               if_valid, if_inst, if_pc, if_pc_next);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_req: req=%0b addr=%h v=%0b want 1/0/0", imem_req, imem_addr, if_valid);
    end
    step();
    total++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wait_cycle: req=%0b v=%0b want 0/0", imem_req, if_valid);
    end
    step();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h5A5A_0000 || if_pc_next !== 32'h1) begin
      bad++;
      $display("[TB] FAIL first_inst: v=%0b pc=%h inst=%h pcn=%h want 1/0/5a5a0000/1",
               if_valid, if_pc, if_inst, if_pc_next);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h1) begin
      bad++;
      $display("[TB] FAIL second_req: req=%0b addr=%h want 1/1", imem_req, imem_addr);
    end
  endtask

  // Sequential fetch: granted addresses and delivered pcs count 0,1,2,3.
  task automatic test_sequential();
    int          got;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    do_reset(1);
    got = 0; exp_pc = 0; exp_req = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      if (imem_req && imem_gnt) begin
        total++;
        if (imem_addr !== exp_req) begin
          bad++;
          $display("[TB] FAIL seq_addr: got %h want %h", imem_addr, exp_req);
        end
        exp_req++;
      end
      if (if_valid) begin
        total++;
        if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc) || if_pc_next !== exp_pc + 1) begin
          bad++;
          $display("[TB] FAIL seq_inst: pc=%h inst=%h pcn=%h want pc=%h inst=%h pcn=%h",
                   if_pc, if_inst, if_pc_next, exp_pc, mem_word(exp_pc), exp_pc + 1);
        end
        exp_pc++;
        got++;
      end
    end
    total++;
    if (got != 4) begin
      bad++;
      $display("[TB] FAIL seq_count: delivered %0d want 4", got);
    end
  endtask

  // Stall with pc 4 in IF/ID: hold, park 5 in skid, no request, then 5,6,7.
  task automatic test_stall();
    int          got;
    logic [31:0] exp_pc;
    bit          found;
    do_reset(1);
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (if_valid === 1'b1 && if_pc === 32'h4) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL stall_setup: pc 4 never reached IF/ID");
    end
    id_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== mem_word(32'h4) || if_pc_next !== 32'h5) begin
        bad++;
        $display("[TB] FAIL stall_hold: v=%0b pc=%h inst=%h pcn=%h want 1/4/%h/5",
                 if_valid, if_pc, if_inst, if_pc_next, mem_word(32'h4));
      end
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall_no_req: req=%0b addr=%h want req=0", imem_req, imem_addr);
      end
    end
    id_stall = 1'b0;
    got = 0; exp_pc = 5;
    for (int c = 0; c < 40 && got < 3; c++) begin
      step();
      if (if_valid) begin
        total++;
        if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc)) begin
          bad++;
          $display("[TB] FAIL stall_order: pc=%h inst=%h want pc=%h inst=%h",
                   if_pc, if_inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc++;
        got++;
      end
    end
    total++;
    if (got != 3) begin
      bad++;
      $display("[TB] FAIL stall_count: delivered %0d want 3", got);
    end
  endtask

  // Redirect to 0x40 while waiting (k=3) for address 7.
  task automatic test_redirect_wait();
    bit found;
    bit req_seen;
    bit got;
    do_reset(3);
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      step();
      if (imem_req === 1'b1 && imem_gnt === 1'b1 && imem_addr === 32'h7) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL rw_setup: request for 7 never granted");
    end
    step();
    br_taken  = 1'b1;
    br_target = 32'h40;
    step();
    br_taken = 1'b0;
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rw_flush: v=%0b req=%0b want 0/0", if_valid, imem_req);
    end
    req_seen = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (imem_req && !req_seen) begin
        req_seen = 1;
        total++;
        if (imem_addr !== 32'h40) begin
          bad++;
          $display("[TB] FAIL rw_addr: got %h want 00000040", imem_addr);
        end
      end
      if (if_valid) begin
        got = 1;
        total++;
        if (if_pc !== 32'h40 || if_inst !== mem_word(32'h40) || if_pc_next !== 32'h41) begin
          bad++;
          $display("[TB] FAIL rw_first: pc=%h inst=%h pcn=%h want 40/%h/41",
                   if_pc, if_inst, if_pc_next, mem_word(32'h40));
        end
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL rw_timeout: no instruction after redirect");
    end
  endtask

  // Redirect to 0x80 while REQ for 3 is held without grant.
  task automatic test_redirect_req();
    bit found;
    bit got;
    do_reset(1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (imem_req === 1'b1 && imem_gnt === 1'b1 && imem_addr === 32'h2) found = 1;
    end
    gnt_en = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (imem_req === 1'b1 && imem_addr === 32'h3) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL rr_setup: request for 3 never seen");
    end
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3) begin
        bad++;
        $display("[TB] FAIL rr_hold: req=%0b addr=%h want 1/3", imem_req, imem_addr);
      end
    end
    br_taken  = 1'b1;
    br_target = 32'h80;
    step();
    br_taken = 1'b0;
    gnt_en   = 1'b1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      bad++;
      $display("[TB] FAIL rr_addr: req=%0b addr=%h want 1/80", imem_req, imem_addr);
    end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (if_valid) begin
        got = 1;
        total++;
        if (if_pc !== 32'h80 || if_inst !== mem_word(32'h80)) begin
          bad++;
          $display("[TB] FAIL rr_first: pc=%h inst=%h want 80/%h", if_pc, if_inst, mem_word(32'h80));
        end
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL rr_timeout: no instruction after redirect");
    end
  endtask

  // Redirect coincident with rvalid while IF/ID is stalled on pc 1.
  task automatic test_redirect_rvalid();
    bit found;
    bit got;
    do_reset(1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (if_valid === 1'b1 && if_pc === 32'h1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL rv_setup: pc 1 never reached IF/ID");
    end
    id_stall = 1'b1;
    step();
    br_taken  = 1'b1;
    br_target = 32'h20;
    step();
    br_taken = 1'b0;
    total++;
    if (if_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rv_flush: v=%0b want 0", if_valid);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      bad++;
      $display("[TB] FAIL rv_addr: req=%0b addr=%h want 1/20", imem_req, imem_addr);
    end
    id_stall = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (if_valid) begin
        got = 1;
        total++;
        if (if_pc !== 32'h20 || if_inst !== mem_word(32'h20)) begin
          bad++;
          $display("[TB] FAIL rv_first: pc=%h inst=%h want 20/%h", if_pc, if_inst, mem_word(32'h20));
        end
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL rv_timeout: no instruction after redirect");
    end
  endtask

  // PC wrap: redirect to all-ones on the granted first request, expect
  // FFFFFFFF then 0, with the stale response for 0 dropped.
  task automatic test_wrap();
    int          got;
    logic [31:0] exp_pc;
    do_reset(1);
    step();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFF;
    step();
    br_taken = 1'b0;
    got = 0; exp_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 30 && got < 2; c++) begin
      step();
      if (if_valid) begin
        total++;
        if (if_pc !== exp_pc || if_inst !== mem_word(exp_pc) || if_pc_next !== exp_pc + 1) begin
          bad++;
          $display("[TB] FAIL wrap_inst: pc=%h inst=%h pcn=%h want pc=%h inst=%h pcn=%h",
                   if_pc, if_inst, if_pc_next, exp_pc, mem_word(exp_pc), exp_pc + 1);
        end
        exp_pc++;
        got++;
      end
    end
    total++;
    if (got != 2) begin
      bad++;
      $display("[TB] FAIL wrap_count: delivered %0d want 2", got);
    end
  endtask

  // Reset asserted while a read for 1 is outstanding; a stray rvalid right
  // after release must be ignored and fetch restarts at address 0.
  task automatic test_reset_in_wait();
    bit found;
    bit got;
    do_reset(3);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (imem_req === 1'b1 && imem_gnt === 1'b1 && imem_addr === 32'h1) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL rst_setup: request for 1 never granted");
    end
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_inst !== 32'h0 || if_pc !== 32'h0 || if_pc_next !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_async: req=%0b addr=%h v=%0b inst=%h pc=%h pcn=%h want all 0",
               imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_next);
    end
    lat = 1;
    step();
    inject_rv = 1'b1;
    step();
    rst_n     = 1'b1;
    inject_rv = 1'b0;
    step();
    total++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_stray: v=%0b req=%0b addr=%h want 0/1/0", if_valid, imem_req, imem_addr);
    end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      if (if_valid) begin
        got = 1;
        total++;
        if (if_pc !== 32'h0 || if_inst !== 32'h5A5A_0000) begin
          bad++;
          $display("[TB] FAIL rst_restart: pc=%h inst=%h want 0/5a5a0000", if_pc, if_inst);
        end
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL rst_timeout: no instruction after reset");
    end
  endtask

  initial begin
    $display("[TB] inst_fetch directed bench start");
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_rvalid();
    test_wrap();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
